// File: rtl/shift_result.sv
// -----------------------------------------------------------------------------
// shift_result
//   Multi-cycle 32-bit shifter. One bit of shifting per clock: the operand is
//   shifted left once per SHIFT cycle, with the fill bit inserted at bit 0.
//   Right shifts are done by the producer handing in a bit-reversed operand.
//   The result is bit-reversed back on the way out. The shift amount p is the
//   index of the highest set bit of the one-hot-with-fill shift pattern.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand set present on right/shift/datain
//   in_ready  : block is IDLE and can accept an operand set
//   right     : 1 = datain is bit-reversed (right shift); result is reversed back
//   shift     : shift pattern, highest set bit = shift amount, bit 0 = fill request
//   datain    : operand
//   out_valid : result is valid (DONE state)
//   out_ready : downstream accepts the result
//   result    : shifted result in normal bit order, 0 while out_valid is low
//   busy      : FSM is not IDLE
// -----------------------------------------------------------------------------
module shift_result (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        right,
    input  logic [31:0] shift,
    input  logic [31:0] datain,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] acc_r;
    logic [4:0]  cnt_r;
    logic        fill_r;
    logic        rev_r;

    logic [4:0]  p_s;
    logic        fill_in_s;
    logic        accept_s;

    // Index of the highest set bit; an all-zero vector maps to 0.
    function automatic logic [4:0] msb_index(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = i[4:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Mirror the bit order of a 32-bit word.
    function automatic logic [31:0] bit_reverse(input logic [31:0] v);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    // Decode of the incoming operand set; fill is only meaningful for a non-zero shift.
    always_comb begin
        p_s       = msb_index(shift);
        fill_in_s = shift[0] & (p_s != 5'd0);
        accept_s  = in_valid & (state_r == ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; DONE never accepts, so back-to-back operations have an IDLE gap.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = (p_s == 5'd0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == 5'd1) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: load on accept, one left shift with fill per SHIFT cycle, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= 32'd0;
            cnt_r  <= 5'd0;
            fill_r <= 1'b0;
            rev_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_r  <= datain;
                        cnt_r  <= p_s;
                        fill_r <= fill_in_s;
                        rev_r  <= right;
                    end else begin
                        acc_r  <= acc_r;
                        cnt_r  <= cnt_r;
                        fill_r <= fill_r;
                        rev_r  <= rev_r;
                    end
                end
                ST_SHIFT: begin
                    acc_r <= {acc_r[30:0], fill_r};
                    cnt_r <= cnt_r - 5'd1;
                end
                default: begin
                    acc_r <= acc_r;
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Output decode, driven purely from registered state; result is masked outside DONE.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        result    = 32'd0;
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_SHIFT: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (rev_r) begin
                    result = bit_reverse(acc_r);
                end else begin
                    result = acc_r;
                end
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_result.sv
module tb_shift_result;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        right;
    logic [31:0] shift;
    logic [31:0] datain;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int vectors;
    int miscompares;

    shift_result dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .right     (right),
        .shift     (shift),
        .datain    (datain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [31:0] sh;
        logic [31:0] d;
        int          stall;
        int          lat;
        logic [31:0] res;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] t;
        t = {<<{v}};
        return t;
    endfunction

    // Reference model: shift amount from the pattern, result from plain shifts and masks.
    function automatic int model_p(input logic [31:0] sh);
        int p;
        p = 0;
        for (int i = 0; i < 32; i++) if (sh[i]) p = i;
        return p;
    endfunction

    function automatic logic [31:0] model_res(input logic r, input logic [31:0] sh, input logic [31:0] d);
        int          p;
        logic        fill;
        logic [31:0] ones;
        logic [31:0] x;
        p    = model_p(sh);
        fill = sh[0] && (p != 0);
        ones = 32'hFFFF_FFFF;
        if (!r) return (d << p) | (fill ? ~(ones << p) : 32'h0);
        x = rev32(d);
        return (x >> p) | (fill ? ~(ones >> p) : 32'h0);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One full operation: accept, wait for out_valid, optional backpressure, return to IDLE.
    task automatic run_op(input string name, input logic r, input logic [31:0] sh, input logic [31:0] d,
                          input int stall, input int exp_lat, input logic [31:0] exp_res);
        int          lat;
        logic        bad;
        logic [31:0] held;
        @(negedge clk);
        check32({name, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        right     = r;
        shift     = sh;
        datain    = d;
        out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (result !== 32'd0 || busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            right    = 1'($urandom_range(0, 1));
            shift    = $urandom;
            datain   = $urandom;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check32({name, " busy phase flags"}, {31'd0, bad}, 32'd0);
        check32({name, " latency"}, 32'(lat), 32'(exp_lat));
        check32({name, " result"}, result, exp_res);
        held = result;
        bad  = 1'b0;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            shift    = $urandom;
            datain   = $urandom;
            @(posedge clk);
            @(negedge clk);
            if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        check32({name, " hold flags"}, {31'd0, bad}, 32'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check32({name, " back to idle"}, {in_ready, out_valid, busy, 29'd0} | (result & 32'h1FFF_FFFF),
                {1'b1, 1'b0, 1'b0, 29'd0});
    endtask

    initial begin
        int          n_valid;
        logic        r;
        logic [31:0] sh;
        logic [31:0] d;
        int          p;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        right       = 1'b0;
        shift       = 32'd0;
        datain      = 32'd0;
        out_ready   = 1'b1;

        tbl[0] = '{1'b0, 32'h0000_0010, 32'h0000_00F1,        5, 4,  32'h0000_0F10};
        tbl[1] = '{1'b1, 32'h0000_00FF, rev32(32'h8000_0010), 0, 7,  32'hFF00_0000};
        tbl[2] = '{1'b1, 32'h0000_0001, rev32(32'h1234_5678), 0, 0,  32'h1234_5678};
        tbl[3] = '{1'b0, 32'h8000_0000, 32'h0000_0001,        0, 31, 32'h8000_0000};
        tbl[4] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF,        1, 0,  32'hDEAD_BEEF};
        tbl[5] = '{1'b0, 32'h0000_0007, 32'h0000_0001,        0, 2,  32'h0000_0007};
        tbl[6] = '{1'b1, 32'h0000_0100, rev32(32'hABCD_1234), 2, 8,  32'h00AB_CD12};
        tbl[7] = '{1'b1, 32'h0000_0003, rev32(32'h4000_0000), 0, 1,  32'hA000_0000};

        // Reset state
        repeat (2) @(negedge clk);
        check32("reset outputs", {in_ready, out_valid, busy, 29'd0}, {1'b1, 1'b0, 1'b0, 29'd0});
        check32("reset result", result, 32'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].r, tbl[i].sh, tbl[i].d, tbl[i].stall, tbl[i].lat, tbl[i].res);
        end

        // Reset in the middle of a p=31 operation
        @(negedge clk);
        in_valid = 1'b1;
        right    = 1'b0;
        shift    = 32'h8000_0000;
        datain   = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check32("midop busy before reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check32("midop reset outputs", {in_ready, out_valid, busy, 29'd0}, {1'b1, 1'b0, 1'b0, 29'd0});
        check32("midop reset result", result, 32'd0);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        n_valid = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || result !== 32'd0) n_valid++;
        end
        check32("no stale result after reset", 32'(n_valid), 32'd0);
        run_op("post reset op", 1'b0, 32'h0000_0004, 32'h0000_0003, 0, 2, 32'h0000_000C);

        // Randomized operations against the reference model
        for (int k = 0; k < 40; k++) begin
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            p = $urandom_range(0, 31);
            case ($urandom_range(0, 5))
                0:       sh = 32'd0;
                1:       sh = $urandom;
                2:       sh = (32'd1 << p) | ((32'd1 << p) - 32'd1);
                default: sh = 32'd1 << p;
            endcase
            run_op($sformatf("rand%0d", k), r, sh, d, $urandom_range(0, 3), model_p(sh), model_res(r, sh, d));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_result.md
SHIFT_RESULT -- requirements
Module: shift_result

Interface
REQ-001 SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  an operand set is present on right/shift/datain.
REQ-005 in_ready  output  1  the block can accept an operand set.
REQ-006 right  input  1  1 = right shift: datain is bit-reversed, so the result is reversed back.
REQ-007 shift  input  32  shift pattern: a single 1 at bit p (p = shift amount); bits below p are all-ones for an arithmetic-fill request, all-zeros otherwise.
REQ-008 datain  input  32  operand, already bit-reversed when right=1.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 result  output  32  shifted result, in normal (unreversed) bit order.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE; in_ready = (state==IDLE), and out_valid = (state==DONE).
REQ-014 Accept SHALL occur on a rising edge with in_valid & in_ready: register acc<=datain, rev<=right, cnt<=p, and fill<=shift[0] & (p!=0).
REQ-015 p SHALL be the index of the highest set bit of shift; shift==0 SHALL be treated as p=0 with fill=0.
REQ-016 On accept, next state SHALL be DONE if p==0, else SHIFT.
REQ-017 In SHIFT, each cycle SHALL update acc<={acc[30:0],fill} and cnt<=cnt-1; when cnt==1, next state is DONE.
REQ-018 out_valid SHALL first be high p rising edges after the accepting edge (p=0: in the cycle after accept); the total latency is p+1 cycles.
REQ-019 result SHALL be bit-reverse(acc) when rev=1, else acc; it is held stable while out_valid=1 and out_ready=0.
REQ-020 In DONE with out_ready=1, next state SHALL be IDLE; there is no accept in that same cycle (maximum one operation per p+2 cycles).
REQ-021 Inputs SHALL be ignored outside IDLE, and in_valid may toggle freely there.
REQ-022 result SHALL be 0 whenever out_valid=0.
REQ-023 Net behaviour: right=0 gives datain<<p; right=1 with fill=0 gives logical right shift; right=1 with fill=1 gives arithmetic right shift with sign fill.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, acc=0, cnt=0, fill=0 and rev=0.
REQ-025 During reset, the outputs SHALL be in_ready=1, out_valid=0, busy=0 and result=0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no out_valid pulse; after release, the first edge may accept a new operand.

Verification
REQ-027 Left shift: right=0, datain=0x0000_00F1, shift=0x0000_0010 (p=4, fill 0). out_valid rises 4 edges after accept, with result=0x0000_0F10.
REQ-028 Arithmetic right: right=1, datain=reverse(0x8000_0010), shift=0x0000_00FF (p=7, fill=1). result=0xFF00_0000.
REQ-029 Logical right p=0: right=1, datain=reverse(0x1234_5678), shift=0x1. out_valid in the cycle after accept, with result=0x1234_5678.
REQ-030 Backpressure: hold out_ready=0 for 5 cycles in DONE. result is stable, in_ready=0, and a new in_valid is ignored; release, and IDLE follows one cycle later.
REQ-031 Reset mid-op: p=31 operation, rst_n low after 10 SHIFT cycles. out_valid=0 and result=0 immediately, and no stale result after release.
REQ-032 Max shift: right=0, datain=0x1, shift=0x8000_0000. result=0x8000_0000 after 31 SHIFT cycles.
